// File: rtl/lockin_pkg.sv
// lockin_pkg: shared types and default widths for the lock-in sequencer.
//   state_e      sequencer FSM states
//   Q_SUMAS_DEF  default width of the lock-in phase/quadrature results
//   TIMEOUT_W    width of the RUN-state watchdog counter
//   CLR_W        width of the CLEAR-state cycle counter (CLR_CYCLES up to 15)
package lockin_pkg;

  localparam int unsigned Q_SUMAS_DEF = 32;
  localparam int unsigned TIMEOUT_W   = 16;
  localparam int unsigned CLR_W       = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StArm,
    StRun,
    StCapture,
    StHold
  } state_e;

endpackage

// File: rtl/lockin_watchdog.sv
// lockin_watchdog: counts enabled cycles and flags expiry on the LIMIT-th one.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   clear    zero the counter (has priority over enable)
//   enable   count this cycle
//   expired  high during the LIMIT-th consecutive enabled cycle
module lockin_watchdog
  import lockin_pkg::*;
#(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  assign expired = enable && !clear && (cnt_q == TIMEOUT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lockin_sequencer.sv
// lockin_sequencer: runs one lock-in measurement per start request.
// Clears the lock-in datapath, waits for a trigger-aligned sample, forwards samples until the
// datapath reports done, then captures and holds the phase/quadrature results until acked.
// Optional feature: define LOCKIN_SEQ_TIMEOUT_EN to add a RUN-state watchdog (lockin_watchdog).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, abort                 measurement request / cancel
//   trig, adc_valid              phase-zero marker, ADC sample strobe
//   lockin_rst_n, lockin_x_valid reset and gated sample strobe to the lock-in datapath
//   lockin_done                  datapath result valid (level)
//   lockin_fase, lockin_cuad     datapath accumulators
//   res_fase, res_cuad           captured results
//   res_valid, res_ack           result handshake
//   busy, timeout_err            not-idle status, sticky watchdog-expiry flag
module lockin_sequencer
  import lockin_pkg::*;
#(
  parameter int unsigned Q_sumas        = Q_SUMAS_DEF,
  parameter int unsigned CLR_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      trig,
  input  logic                      adc_valid,
  output logic                      lockin_rst_n,
  output logic                      lockin_x_valid,
  input  logic                      lockin_done,
  input  logic signed [Q_sumas-1:0] lockin_fase,
  input  logic signed [Q_sumas-1:0] lockin_cuad,
  output logic signed [Q_sumas-1:0] res_fase,
  output logic signed [Q_sumas-1:0] res_cuad,
  output logic                      res_valid,
  input  logic                      res_ack,
  output logic                      busy,
  output logic                      timeout_err
);

  state_e                    state_q, state_d;
  logic [CLR_W-1:0]          clr_cnt_q, clr_cnt_d;
  logic signed [Q_sumas-1:0] res_fase_q, res_cuad_q;
  logic                      res_valid_q;
  logic                      capture;
  logic                      wd_expired;

`ifdef LOCKIN_SEQ_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;

  lockin_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_q != StRun),
    .enable (state_q == StRun),
    .expired(wd_expired)
  );

  always_comb begin
    timeout_err_d = timeout_err_q;
    if (state_q == StIdle && start) begin
      timeout_err_d = 1'b0;
    end else if (state_q == StRun && wd_expired && !lockin_done && !abort) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = '0;
    lockin_rst_n   = 1'b1;
    lockin_x_valid = 1'b0;
    capture        = 1'b0;
    unique case (state_q)
      StIdle: begin
        lockin_rst_n = 1'b0;
        if (start) state_d = StClear;
      end
      StClear: begin
        lockin_rst_n = 1'b0;
        if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = StArm;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      StArm: begin
        // The trigger-aligned sample is the first one the datapath sees.
        if (trig && adc_valid && !abort) begin
          lockin_x_valid = 1'b1;
          state_d        = StRun;
        end
      end
      StRun: begin
        if (lockin_done) begin
          state_d = StCapture;
          capture = 1'b1;
        end else begin
          lockin_x_valid = adc_valid;
          if (wd_expired) state_d = StIdle;
        end
      end
      StCapture: state_d = StHold;
      StHold: begin
        if (res_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort && state_q != StIdle) begin
      state_d   = StIdle;
      clr_cnt_d = '0;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      res_fase_q  <= '0;
      res_cuad_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      // Results are taken on the edge that enters CAPTURE so res_valid follows done by one cycle.
      if (capture) begin
        res_fase_q <= lockin_fase;
        res_cuad_q <= lockin_cuad;
      end
      res_valid_q <= (state_d == StCapture) || (state_d == StHold);
    end
  end

  assign res_fase  = res_fase_q;
  assign res_cuad  = res_cuad_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != StIdle);

endmodule
